// File: rtl/mux_select_stream_pkg.sv
// gsu_pkg: mode and state encodings shared by the GSU channel-select stream block.
package gsu_pkg;
  localparam logic MODE_SINGLE = 1'b0;
  localparam logic MODE_SCAN = 1'b1;
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;
endpackage

// File: rtl/mux_select_stream_if.sv
// mux_select_stream_if: request handshake plus output beat stream of the channel selector.
interface mux_select_stream_if #(
  parameter int WIDTH = 16,
  parameter int CHANNELS = 16
);
  localparam int SEL_W = $clog2(CHANNELS);
  logic req_valid;
  logic req_ready;
  logic req_mode;
  logic [SEL_W-1:0] req_sel;
  logic [SEL_W-1:0] req_count;
  logic out_valid;
  logic out_ready;
  logic [WIDTH-1:0] out_data;
  logic [SEL_W-1:0] out_channel;
  logic out_last;
  modport slave (
    input req_valid, req_mode, req_sel, req_count, out_ready,
    output req_ready, out_valid, out_data, out_channel, out_last
  );
  modport master (
    output req_valid, req_mode, req_sel, req_count, out_ready,
    input req_ready, out_valid, out_data, out_channel, out_last
  );
endinterface

// File: rtl/mux_select_stream_core.sv
// mux_select_core: combinational N-of-W channel select; indices past CHANNELS-1 read as zero.
module mux_select_core #(
  parameter int WIDTH = 16,
  parameter int CHANNELS = 16,
  localparam int SEL_W = $clog2(CHANNELS)
) (
  input  logic [CHANNELS*WIDTH-1:0] data,
  input  logic [SEL_W-1:0]          sel,
  output logic [WIDTH-1:0]          y
);
  always_comb begin
    y = '0;
    for (int i = 0; i < CHANNELS; i++) y = (sel == SEL_W'(i)) ? data[i*WIDTH +: WIDTH] : y;
  end
endmodule

// File: rtl/mux_select_stream.sv
// mux_select_stream: registered, handshaked single/scan channel readout of a packed channel bus.
module mux_select_stream
  import gsu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHANNELS = 16,
  localparam int SEL_W = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] data_input,
  output logic                      busy,
  mux_select_stream_if.slave        bus
);
  logic [0:0] state;
  logic [SEL_W-1:0] remaining, channel, nxt, sel;
  logic [WIDTH-1:0] data, mux;
  logic valid, last;
  // out-of-range starts wrap straight to 0 after their single zero beat
  assign nxt = (channel >= SEL_W'(CHANNELS - 1)) ? '0 : channel + 1'b1;
  assign sel = (state == ST_IDLE) ? bus.req_sel : nxt;
  mux_select_core #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) u_core (
    .data(data_input),
    .sel (sel),
    .y   (mux)
  );
  assign bus.req_ready = (state == ST_IDLE);
  assign busy = (state != ST_IDLE);
  assign bus.out_valid = valid;
  assign bus.out_data = data;
  assign bus.out_channel = channel;
  assign bus.out_last = last;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      valid <= 1'b0;
      data <= '0;
      channel <= '0;
      last <= 1'b0;
      remaining <= '0;
    end else if (state == ST_IDLE) begin
      if (bus.req_valid) begin
        data <= mux;
        channel <= bus.req_sel;
        valid <= 1'b1;
        remaining <= (bus.req_mode == MODE_SCAN) ? bus.req_count : '0;
        last <= (bus.req_mode == MODE_SCAN) ? (bus.req_count == '0) : 1'b1;
        state <= ST_SEND;
      end
    end else if (valid && bus.out_ready) begin
      if (last) begin
        valid <= 1'b0;
        last <= 1'b0;
        state <= ST_IDLE;
      end else begin
        data <= mux;
        channel <= nxt;
        remaining <= remaining - 1'b1;
        last <= (remaining == SEL_W'(1));
      end
    end
  end
endmodule

// File: tb/tb_mux_select_stream.sv
// tb_mux_select_stream: directed checks of single, scan, back-pressure, non-power-of-two and reset behaviour.
module tb_mux_select_stream;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [16*16-1:0] data16;
  logic [12*16-1:0] data12;
  logic busy16, busy12;
  int compared = 0;
  int mismatched = 0;
  always #5 clk = ~clk;
  mux_select_stream_if #(.WIDTH(16), .CHANNELS(16)) b16 ();
  mux_select_stream_if #(.WIDTH(16), .CHANNELS(12)) b12 ();
  mux_select_stream #(.WIDTH(16), .CHANNELS(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .data_input(data16), .busy(busy16), .bus(b16)
  );
  mux_select_stream #(.WIDTH(16), .CHANNELS(12)) dut12 (
    .clk(clk), .rst_n(rst_n), .data_input(data12), .busy(busy12), .bus(b12)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic beat16(input string tag, input int ch, input int d, input bit l);
    chk({tag, ".valid"}, 32'(b16.out_valid), 1);
    chk({tag, ".chan"}, 32'(b16.out_channel), ch);
    chk({tag, ".data"}, 32'(b16.out_data), d);
    chk({tag, ".last"}, 32'(b16.out_last), 32'(l));
  endtask
  task automatic beat12(input string tag, input int ch, input int d, input bit l);
    chk({tag, ".valid"}, 32'(b12.out_valid), 1);
    chk({tag, ".chan"}, 32'(b12.out_channel), ch);
    chk({tag, ".data"}, 32'(b12.out_data), d);
    chk({tag, ".last"}, 32'(b12.out_last), 32'(l));
  endtask
  task automatic req16(input bit mode, input int sel, input int cnt);
    b16.req_valid = 1'b1;
    b16.req_mode = mode;
    b16.req_sel = 4'(sel);
    b16.req_count = 4'(cnt);
    tick();
    b16.req_valid = 1'b0;
  endtask
  task automatic req12(input bit mode, input int sel, input int cnt);
    b12.req_valid = 1'b1;
    b12.req_mode = mode;
    b12.req_sel = 4'(sel);
    b12.req_count = 4'(cnt);
    tick();
    b12.req_valid = 1'b0;
  endtask
  initial begin
    int exp_ch[4];
    for (int i = 0; i < 16; i++) data16[i*16 +: 16] = 16'hA000 + 16'(i);
    for (int i = 0; i < 12; i++) data12[i*16 +: 16] = 16'hB000 + 16'(i);
    b16.req_valid = 1'b0; b16.req_mode = 1'b0; b16.req_sel = '0; b16.req_count = '0; b16.out_ready = 1'b1;
    b12.req_valid = 1'b0; b12.req_mode = 1'b0; b12.req_sel = '0; b12.req_count = '0; b12.out_ready = 1'b1;
    tick();
    tick();
    chk("rst.valid", 32'(b16.out_valid), 0);
    chk("rst.data", 32'(b16.out_data), 0);
    chk("rst.busy", 32'(busy16), 0);
    chk("rst.ready", 32'(b16.req_ready), 1);
    rst_n = 1'b1;
    tick();
    chk("idle.valid", 32'(b16.out_valid), 0);
    req16(1'b0, 5, 9);
    beat16("single", 5, 16'hA005, 1'b1);
    chk("single.busy", 32'(busy16), 1);
    chk("single.ready", 32'(b16.req_ready), 0);
    tick();
    chk("single.done.valid", 32'(b16.out_valid), 0);
    chk("single.done.busy", 32'(busy16), 0);
    chk("single.done.ready", 32'(b16.req_ready), 1);
    exp_ch = '{14, 15, 0, 1};
    req16(1'b1, 14, 3);
    for (int b = 0; b < 4; b++) begin
      beat16($sformatf("wrap%0d", b), exp_ch[b], 16'hA000 + exp_ch[b], b == 3);
      tick();
    end
    chk("wrap.end.valid", 32'(b16.out_valid), 0);
    req16(1'b1, 0, 2);
    beat16("bp0", 0, 16'hA000, 1'b0);
    tick();
    beat16("bp1", 1, 16'hA001, 1'b0);
    b16.out_ready = 1'b0;
    data16[1*16 +: 16] = 16'h5555;
    b16.req_valid = 1'b1;
    b16.req_sel = 4'd9;
    b16.req_mode = 1'b0;
    for (int s = 0; s < 3; s++) begin
      tick();
      beat16($sformatf("bp.hold%0d", s), 1, 16'hA001, 1'b0);
    end
    b16.req_valid = 1'b0;
    data16[2*16 +: 16] = 16'h7777;
    b16.out_ready = 1'b1;
    tick();
    beat16("bp2", 2, 16'h7777, 1'b1);
    data16[1*16 +: 16] = 16'hA001;
    data16[2*16 +: 16] = 16'hA002;
    tick();
    chk("bp.end.valid", 32'(b16.out_valid), 0);
    req12(1'b0, 13, 0);
    beat12("np2.single", 13, 0, 1'b1);
    tick();
    exp_ch = '{10, 11, 0, 0};
    req12(1'b1, 10, 2);
    for (int b = 0; b < 3; b++) begin
      beat12($sformatf("np2.scan%0d", b), exp_ch[b], 16'hB000 + exp_ch[b], b == 2);
      tick();
    end
    chk("np2.end.valid", 32'(b12.out_valid), 0);
    req12(1'b1, 13, 1);
    beat12("np2.oor0", 13, 0, 1'b0);
    tick();
    beat12("np2.oor1", 0, 16'hB000, 1'b1);
    tick();
    req16(1'b1, 0, 7);
    beat16("mid0", 0, 16'hA000, 1'b0);
    tick();
    beat16("mid1", 1, 16'hA001, 1'b0);
    tick();
    beat16("mid2", 2, 16'hA002, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid.rst.valid", 32'(b16.out_valid), 0);
    chk("mid.rst.data", 32'(b16.out_data), 0);
    chk("mid.rst.last", 32'(b16.out_last), 0);
    chk("mid.rst.busy", 32'(busy16), 0);
    chk("mid.rst.ready", 32'(b16.req_ready), 1);
    tick();
    rst_n = 1'b1;
    for (int s = 0; s < 3; s++) begin
      tick();
      chk($sformatf("post.rst.valid%0d", s), 32'(b16.out_valid), 0);
    end
    req16(1'b0, 3, 0);
    beat16("post.rst.req", 3, 16'hA003, 1'b1);
    tick();
    chk("post.rst.end.valid", 32'(b16.out_valid), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
